// File: rtl/multicycle_sequencer_if.sv
// multicycle_sequencer_if: control, status and memory handshake bundle of the sequencer.
interface multicycle_sequencer_if #(parameter int CNT_W = 32);
  logic             start;
  logic [5:0]       opcode;
  logic             alu_zero;
  logic             mem_ready;
  logic             ir_write;
  logic             pc_write;
  logic             decode_en;
  logic             alu_en;
  logic             mem_req;
  logic             mem_we;
  logic             stack_en;
  logic             reg_write;
  logic [2:0]       state;
  logic             halted;
  logic             fault;
  logic [CNT_W-1:0] retired;
  modport master (
    input  start, opcode, alu_zero, mem_ready,
    output ir_write, pc_write, decode_en, alu_en, mem_req, mem_we, stack_en, reg_write,
    output state, halted, fault, retired
  );
  modport slave (
    output start, opcode, alu_zero, mem_ready,
    input  ir_write, pc_write, decode_en, alu_en, mem_req, mem_we, stack_en, reg_write,
    input  state, halted, fault, retired
  );
endinterface

// File: rtl/multicycle_sequencer.sv
// multicycle_sequencer: FETCH/DECODE/EXEC/MEM/WB control FSM with memory timeout and retire count.
module multicycle_sequencer #(
  parameter int MEM_TIMEOUT = 15,
  parameter int CNT_W       = 32
) (
  input logic                    clk,
  input logic                    rst,
  multicycle_sequencer_if.master bus
);
  typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALT, FAULT} state_e;
  localparam int WW = $clog2(MEM_TIMEOUT + 1);
  localparam logic [5:0] OP_R = 6'h00, OP_ADDI = 6'h08, OP_LW = 6'h23, OP_SW = 6'h2B, OP_BEQ = 6'h04;
  localparam logic [5:0] OP_J = 6'h02, OP_PUSH = 6'h30, OP_POP = 6'h31, OP_HALT = 6'h3F;
  state_e           state_q, state_d;
  logic [5:0]       op_q, op_d;
  logic [WW-1:0]    wait_q, wait_d;
  logic [CNT_W-1:0] retired_q, retired_d;
  logic             retire, legal, is_store, is_stack, is_load, mem_state, timeout;
  always_comb begin
    legal          = bus.opcode inside {OP_R, OP_ADDI, OP_LW, OP_SW, OP_BEQ, OP_J, OP_PUSH, OP_POP, OP_HALT};
    is_store       = op_q inside {OP_SW, OP_PUSH};
    is_stack       = op_q inside {OP_PUSH, OP_POP};
    is_load        = op_q inside {OP_LW, OP_POP};
    mem_state      = state_q inside {FETCH, MEM};
    timeout        = mem_state && !bus.mem_ready && wait_q == WW'(MEM_TIMEOUT - 1);
    state_d        = state_q;
    op_d           = op_q;
    retire         = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.decode_en  = 1'b0;
    bus.alu_en     = 1'b0;
    bus.mem_req    = 1'b0;
    bus.mem_we     = 1'b0;
    bus.stack_en   = 1'b0;
    bus.reg_write  = 1'b0;
    case (state_q)
      IDLE: state_d = bus.start ? FETCH : IDLE;
      FETCH: begin
        bus.mem_req  = 1'b1;
        bus.ir_write = bus.mem_ready;
        bus.pc_write = bus.mem_ready;
        state_d      = bus.mem_ready ? DECODE : timeout ? FAULT : FETCH;
      end
      DECODE: begin
        bus.decode_en = 1'b1;
        op_d          = bus.opcode;
        bus.pc_write  = bus.opcode == OP_J;
        retire        = bus.opcode == OP_J;
        state_d       = !legal ? FAULT : bus.opcode == OP_HALT ? HALT : bus.opcode == OP_J ? FETCH : EXEC;
      end
      EXEC: begin
        bus.alu_en   = 1'b1;
        bus.pc_write = op_q == OP_BEQ && bus.alu_zero;
        retire       = op_q == OP_BEQ;
        state_d      = op_q == OP_BEQ ? FETCH : op_q inside {OP_R, OP_ADDI} ? WB : MEM;
      end
      MEM: begin
        bus.mem_req  = 1'b1;
        bus.mem_we   = is_store;
        bus.stack_en = is_stack && bus.mem_ready;
        retire       = is_store && bus.mem_ready;
        state_d      = bus.mem_ready ? (is_load ? WB : FETCH) : timeout ? FAULT : MEM;
      end
      WB: begin
        bus.reg_write = 1'b1;
        retire        = 1'b1;
        state_d       = FETCH;
      end
      default: ;
    endcase
    // staying in FETCH/MEM only happens on a not-ready cycle, so that is what the counter tracks
    wait_d    = (mem_state && state_d == state_q) ? wait_q + 1'b1 : '0;
    retired_d = retired_q + CNT_W'(retire);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      op_q      <= '0;
      wait_q    <= '0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      wait_q    <= wait_d;
      retired_q <= retired_d;
    end
  end
  assign bus.state   = state_q;
  assign bus.halted  = state_q == HALT;
  assign bus.fault   = state_q == FAULT;
  assign bus.retired = retired_q;
endmodule

// File: tb/tb_multicycle_sequencer.sv
// tb_multicycle_sequencer: randomized instruction stream with per-instruction scoreboard.
module tb_multicycle_sequencer;
  localparam int T  = 4;
  localparam int CW = 6;
  localparam logic [2:0] S_IDLE = 0, S_FETCH = 1, S_DEC = 2, S_EXEC = 3, S_MEM = 4, S_HALT = 6, S_FAULT = 7;
  localparam logic [5:0] O_R = 6'h00, O_ADDI = 6'h08, O_LW = 6'h23, O_SW = 6'h2B, O_BEQ = 6'h04;
  localparam logic [5:0] O_J = 6'h02, O_PUSH = 6'h30, O_POP = 6'h31, O_HALT = 6'h3F;
  typedef struct {
    int fin, cyc, req, ir, pc, dec, alu, we, stk, reg_w, ret;
  } exp_t;
  logic clk = 0;
  logic rst = 1;
  exp_t q[$];
  int   total = 0;
  int   bad = 0;
  int   exp_ret = 0;
  multicycle_sequencer_if #(.CNT_W(CW)) bus();
  multicycle_sequencer #(.MEM_TIMEOUT(T), .CNT_W(CW)) dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string name, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, want, $time);
    end
  endtask
  // expected footprint of one instruction, from stage costs and wait counts
  function automatic exp_t model(logic [5:0] op, int fw, int mw, bit z);
    exp_t e = '{default: 0};
    bit   ret = 0;
    int   m = (mw >= T) ? T : mw + 1;
    e.fin = S_FAULT;
    if (fw >= T) begin
      e.cyc = T;
      e.req = T;
    end else begin
      e.cyc = fw + 2;
      e.req = fw + 1;
      e.ir  = 1;
      e.pc  = 1;
      e.dec = 1;
      case (op)
        O_HALT: e.fin = S_HALT;
        O_J: begin e.pc++; ret = 1; end
        O_BEQ: begin e.cyc++; e.alu = 1; e.pc += int'(z); ret = 1; end
        O_R, O_ADDI: begin e.cyc += 2; e.alu = 1; e.reg_w = 1; ret = 1; end
        O_LW, O_SW, O_PUSH, O_POP: begin
          e.alu = 1;
          e.cyc += 1 + m;
          e.req += m;
          if (op == O_SW || op == O_PUSH) e.we = m;
          if (mw < T) begin
            e.stk = (op == O_PUSH || op == O_POP) ? 1 : 0;
            if (op == O_LW || op == O_POP) begin e.cyc++; e.reg_w = 1; end
            ret = 1;
          end
        end
        default: ;
      endcase
    end
    if (ret) begin
      exp_ret = (exp_ret + 1) % (1 << CW);
      e.fin   = S_FETCH;
    end
    e.ret = exp_ret;
    return e;
  endfunction
  exp_t       cur;
  bit         active = 0;
  logic [2:0] prev = S_IDLE;
  always @(negedge clk) begin
    if (rst) begin
      active = 0;
      prev   = S_IDLE;
    end else begin
      if (active && ((bus.state == S_FETCH && prev != S_FETCH) || bus.state == S_HALT || bus.state == S_FAULT)) begin
        exp_t e;
        active = 0;
        if (q.size() == 0) check("sb_underflow", 1, 0);
        else begin
          e = q.pop_front();
          check("end_state", int'(bus.state), e.fin);
          check("cycles", cur.cyc, e.cyc);
          check("mem_req_cycles", cur.req, e.req);
          check("ir_write_count", cur.ir, e.ir);
          check("pc_write_count", cur.pc, e.pc);
          check("decode_en_count", cur.dec, e.dec);
          check("alu_en_count", cur.alu, e.alu);
          check("mem_we_count", cur.we, e.we);
          check("stack_en_count", cur.stk, e.stk);
          check("reg_write_count", cur.reg_w, e.reg_w);
          check("retired", int'(bus.retired), e.ret);
        end
      end
      if (bus.state == S_FETCH && prev != S_FETCH) begin
        active = 1;
        cur    = '{default: 0};
      end
      if (active) begin
        cur.cyc++;
        cur.req   += int'(bus.mem_req);
        cur.ir    += int'(bus.ir_write);
        cur.pc    += int'(bus.pc_write);
        cur.dec   += int'(bus.decode_en);
        cur.alu   += int'(bus.alu_en);
        cur.we    += int'(bus.mem_we && bus.mem_req);
        cur.stk   += int'(bus.stack_en);
        cur.reg_w += int'(bus.reg_write);
      end
      prev = bus.state;
    end
  end
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // drives one instruction from FETCH entry; fw/mw are not-ready cycles before mem_ready
  task automatic run_instr(input logic [5:0] op, input int fw, input int mw, input bit z);
    int fc = 0;
    int mc = 0;
    bit left = 0;
    q.push_back(model(op, fw, mw, z));
    for (int n = 0; n < 64; n++) begin
      if (bus.state == S_HALT || bus.state == S_FAULT || (bus.state == S_FETCH && left)) return;
      if (bus.state != S_FETCH) left = 1;
      bus.start     = 1'($urandom);
      bus.opcode    = (bus.state == S_DEC) ? op : 6'($urandom);
      bus.alu_zero  = (bus.state == S_EXEC) ? z : 1'($urandom);
      bus.mem_ready = (bus.state == S_FETCH) ? (fc == fw) : (bus.state == S_MEM) ? (mc == mw) : 1'($urandom);
      if (bus.state == S_FETCH) fc++;
      if (bus.state == S_MEM) mc++;
      step();
    end
    check("instr_cycle_budget", 1, 0);
  endtask
  task automatic do_start();
    bus.start = 1;
    step();
    bus.start = 0;
    check("start_to_fetch", int'(bus.state), S_FETCH);
  endtask
  task automatic rst_dut();
    rst = 1;
    step();
    rst = 0;
    exp_ret = 0;
  endtask
  logic [5:0] ops[8] = '{O_R, O_ADDI, O_LW, O_SW, O_BEQ, O_J, O_PUSH, O_POP};
  initial begin
    bus.start = 0; bus.opcode = 0; bus.alu_zero = 0; bus.mem_ready = 1;
    repeat (2) step();
    check("rst_state", int'(bus.state), S_IDLE);
    check("rst_strobes", int'({bus.ir_write, bus.pc_write, bus.decode_en, bus.alu_en,
                               bus.mem_req, bus.mem_we, bus.stack_en, bus.reg_write}), 0);
    check("rst_halted", int'(bus.halted), 0);
    check("rst_fault", int'(bus.fault), 0);
    check("rst_retired", int'(bus.retired), 0);
    rst = 0;
    repeat (2) step();
    check("idle_hold", int'(bus.state), S_IDLE);
    check("idle_no_req", int'(bus.mem_req), 0);
    do_start();
    run_instr(O_R, 0, 0, 0);
    run_instr(O_LW, 2, 0, 0);
    run_instr(O_BEQ, 0, 0, 1);
    run_instr(O_BEQ, 0, 0, 0);
    run_instr(O_PUSH, 0, 0, 0);
    run_instr(O_POP, 0, 0, 0);
    run_instr(O_SW, T - 1, T - 1, 0);
    for (int i = 0; i < 150; i++)
      run_instr(ops[$urandom_range(0, 7)], $urandom_range(0, T - 1), $urandom_range(0, T - 1), 1'($urandom));
    run_instr(O_HALT, $urandom_range(0, 1), 0, 0);
    step();
    bus.start = 1;
    repeat (4) step();
    check("halt_ignores_start", int'(bus.state), S_HALT);
    check("halted_flag", int'(bus.halted), 1);
    check("halt_retired", int'(bus.retired), exp_ret);
    check("halt_no_req", int'(bus.mem_req), 0);
    bus.start = 0;
    rst_dut();
    check("halt_rst_idle", int'(bus.state), S_IDLE);
    do_start();
    run_instr(O_R, 0, 0, 0);
    run_instr(O_R, T, 0, 0);
    bus.mem_ready = 1;
    repeat (3) step();
    check("timeout_fault", int'(bus.fault), 1);
    check("timeout_state", int'(bus.state), S_FAULT);
    check("timeout_no_req", int'(bus.mem_req), 0);
    rst_dut();
    check("fault_rst_idle", int'(bus.state), S_IDLE);
    check("fault_rst_retired", int'(bus.retired), 0);
    do_start();
    run_instr(O_ADDI, 1, 0, 0);
    run_instr(O_SW, 0, T, 0);
    step();
    rst_dut();
    do_start();
    run_instr(O_J, 0, 0, 0);
    run_instr(6'h3A, 0, 0, 0);
    step();
    check("illegal_fault", int'(bus.fault), 1);
    rst_dut();
    do_start();
    run_instr(O_R, 0, 0, 0);
    bus.opcode = O_LW; bus.mem_ready = 1;
    step();
    bus.mem_ready = 0;
    repeat (2) step();
    check("midrst_in_mem", int'(bus.state), S_MEM);
    check("midrst_req_before", int'(bus.mem_req), 1);
    rst = 1;
    step();
    check("midrst_idle", int'(bus.state), S_IDLE);
    check("midrst_req_drop", int'(bus.mem_req), 0);
    check("midrst_retired", int'(bus.retired), 0);
    rst = 0;
    step();
    check("scoreboard_drained", q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/multicycle_sequencer.md
# multicycle_sequencer

Multicycle control sequencer for the core datapath. Steps each instruction through FETCH, DECODE, EXECUTE, MEMORY and WRITEBACK, and produces the per-stage enables for the IR, PC, decode/register-file stage, ALU, data memory and stack. Owns the memory request/ready handshake with a stall timeout, and counts retired instructions. Sits beside the decode stage's opcode control unit and gates when its outputs take effect.

## Interface
- MEM_TIMEOUT, 15: consecutive not-ready memory cycles before FAULT (≥1)
- CNT_W, 32: width of retired-instruction counter

- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- start  in  1  leave IDLE and begin fetching
- opcode  in  6  instruction[31:26] from IR, sampled in DECODE
- alu_zero  in  1  ALU zero flag, sampled in EXEC
- mem_ready  in  1  memory completes current request this cycle
- ir_write  out  1  load instruction register
- pc_write  out  1  update PC
- decode_en  out  1  latch decode-stage registers
- alu_en  out  1  ALU stage active
- mem_req  out  1  memory request
- mem_we  out  1  memory write (valid with mem_req)
- stack_en  out  1  stack-pointer update for push/pop
- reg_write  out  1  register-file write strobe
- state  out  3  current state encoding
- halted  out  1  in HALT
- fault  out  1  in FAULT
- retired  out  CNT_W  retired-instruction count

## Operation
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALT=6, FAULT=7.
- Opcode classes: R-type 6'h00, addi 6'h08, lw 6'h23, sw 6'h2B, beq 6'h04, j 6'h02, push 6'h30, pop 6'h31, halt 6'h3F. Anything else is illegal.
- The opcode is registered into an internal op_q in DECODE. Later states use op_q only.
- IDLE: all strobes 0. start=1 → FETCH. start is ignored in every other state.
- FETCH: mem_req=1, mem_we=0.
  - On mem_ready: ir_write=1 and pc_write=1 in that cycle → DECODE.
- DECODE: decode_en=1.
  - halt → HALT.
  - j → pc_write=1, retire → FETCH.
  - Illegal opcode → FAULT.
  - Otherwise → EXEC.
- EXEC: alu_en=1.
  - R-type/addi → WB.
  - lw/sw/push/pop → MEM.
  - beq → pc_write=alu_zero, retire → FETCH.
- MEM: mem_req=1. mem_we=1 for sw/push. stack_en=1 for push/pop.
  - On mem_ready: lw/pop → WB; sw/push → retire → FETCH.
- WB: reg_write=1, retire → FETCH.
- HALT: halted=1, all strobes 0. Left only by rst.
- FAULT: fault=1, all strobes 0. Left only by rst.
- Strobes are decoded from state. ir_write, pc_write and stack_en are additionally gated by mem_ready/alu_zero as stated above.
- Retire: retired += 1 in the retiring cycle. It wraps modulo 2^CNT_W.

## Timing
- Reset values: state=IDLE, every strobe 0, halted=0, fault=0, retired=0, wait counter=0, op_q=0.
- rst mid-instruction: IDLE after the edge. mem_req drops the same edge. retired clears.
- Zero-wait cycle counts: j 2, beq 3, R-type/addi 4, sw 4, push 4, lw 5, pop 5. Each memory wait cycle adds 1.
- Handshake:
  - mem_req is held high with mem_we stable until a cycle with mem_ready=1.
  - mem_ready on the first mem_req cycle completes with zero wait.
  - mem_ready outside FETCH/MEM is ignored.
- Timeout:
  - The wait counter clears on entry to FETCH/MEM and increments each FETCH/MEM cycle with mem_ready=0.
  - At the end of the MEM_TIMEOUT-th consecutive not-ready cycle → FAULT. mem_ready in any earlier cycle completes normally.
- The retire increment and the next FETCH happen on the same edge. An instruction in progress at HALT/FAULT entry is not counted.

## Test plan
- rst, start, R-type, zero-wait memory → state 1,2,3,5,1. reg_write high exactly in cycle 4. retired=1.
- lw with mem_ready low for 2 FETCH cycles, then zero-wait MEM → mem_req high 3 cycles in FETCH. ir_write only on the ready cycle. 7 cycles total. reg_write once.
- beq with alu_zero=1, then beq with alu_zero=0 → pc_write in EXEC only for the first. Each takes 3 cycles (zero-wait). retired=2.
- MEM_TIMEOUT=4, mem_ready held 0 → FAULT after 4 FETCH cycles, fault=1, mem_req=0. Stays until rst. rst → IDLE, retired=0.
- push then pop → push: mem_we=1, stack_en=1 in MEM. pop: mem_we=0, stack_en=1, then reg_write in WB. retired=2.
- Opcode 6'h3A → FAULT after DECODE, retired unchanged. Opcode 6'h3F → halted=1, later start ignored.
